// File: rtl/bcd_pkg.sv
// Shared constants and state encodings for the BCD conversion scheduler and its iterative core.
package bcd_pkg;

  localparam int DEC_1000 = 1000;
  localparam int DEC_100  = 100;
  localparam int DEC_10   = 10;
  localparam int MAX_DEC  = 9999;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SAT,
    S_DONE
  } sched_state_t;

  typedef enum logic [1:0] {
    P_THOU,
    P_HUND,
    P_TENS,
    P_DONE
  } phase_t;

endpackage

// File: rtl/bcd_iter_core.sv
// Iterative binary-to-BCD core: repeated subtraction of 1000/100/10, one step per cycle.
module bcd_iter_core
  import bcd_pkg::*;
#(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] value,
  output logic         done,
  output logic [3:0]   d3,
  output logic [3:0]   d2,
  output logic [3:0]   d1,
  output logic [3:0]   d0
);

  localparam logic [W-1:0] K1000 = W'(DEC_1000);
  localparam logic [W-1:0] K100  = W'(DEC_100);
  localparam logic [W-1:0] K10   = W'(DEC_10);

  phase_t         phase_q, phase_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [3:0]     d3_q, d3_d, d2_q, d2_d, d1_q, d1_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= P_DONE;
    else     phase_q <= phase_d;
  end

  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    d3_q  <= d3_d;
    d2_q  <= d2_d;
    d1_q  <= d1_d;
  end

  // done is raised in the final tens cycle so the ones digit is read straight off the remainder
  always_comb begin
    phase_d = phase_q;
    rem_d   = rem_q;
    d3_d    = d3_q;
    d2_d    = d2_q;
    d1_d    = d1_q;
    done    = 1'b0;
    if (start) begin
      phase_d = P_THOU;
      rem_d   = value;
      d3_d    = 4'd0;
      d2_d    = 4'd0;
      d1_d    = 4'd0;
    end else begin
      case (phase_q)
        P_THOU: begin
          if (rem_q >= K1000) begin
            rem_d = rem_q - K1000;
            d3_d  = d3_q + 4'd1;
          end else begin
            phase_d = P_HUND;
          end
        end
        P_HUND: begin
          if (rem_q >= K100) begin
            rem_d = rem_q - K100;
            d2_d  = d2_q + 4'd1;
          end else begin
            phase_d = P_TENS;
          end
        end
        P_TENS: begin
          if (rem_q >= K10) begin
            rem_d = rem_q - K10;
            d1_d  = d1_q + 4'd1;
          end else begin
            phase_d = P_DONE;
            done    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign d3 = d3_q;
  assign d2 = d2_q;
  assign d1 = d1_q;
  assign d0 = rem_q[3:0];

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin arbiter sharing one bcd_iter_core among NREQ requesters; results are
// registered and presented (with ack) in the cycle after the DONE state.
module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        bin_in,
  output logic [NREQ-1:0]          ack,
  output logic                     res_valid,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic [15:0]              res_bcd,
  output logic                     res_ovf,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);

  sched_state_t    state_q, state_d;
  logic [IDW-1:0]  rr_ptr, gnt_id, gnt_sel, rr_next;
  logic            gnt_hit, fits, core_start, core_done;
  logic [NREQ-1:0] req_m;
  logic [W-1:0]    cap_val;
  logic [3:0]      d3, d2, d1, d0;
  logic [15:0]     dig_q;
  logic            ovf_q;

  // The requester being acked still holds req this cycle; it must not be re-granted.
  assign req_m = req & ~ack;

  always_comb begin
    gnt_hit = 1'b0;
    gnt_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_hit && req_m[(int'(rr_ptr) + k) % NREQ]) begin
        gnt_hit = 1'b1;
        gnt_sel = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign cap_val    = bin_in[gnt_sel*W +: W];
  assign fits       = (cap_val <= W'(MAX_DEC));
  assign rr_next    = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_hit) begin
          state_d    = fits ? S_CONV : S_SAT;
          core_start = fits;
        end
      end
      S_CONV:  if (core_done) state_d = S_DONE;
      S_SAT:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  bcd_iter_core #(.W(W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start),
    .value (cap_val),
    .done  (core_done),
    .d3    (d3),
    .d2    (d2),
    .d1    (d1),
    .d0    (d0)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      ack       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_bcd   <= '0;
      res_ovf   <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_valid <= 1'b0;
      ack       <= '0;
      if (state_q == S_IDLE && gnt_hit) gnt_id <= gnt_sel;
      if (state_q == S_DONE) begin
        res_valid <= 1'b1;
        ack       <= NREQ'(1) << gnt_id;
        res_id    <= gnt_id;
        res_bcd   <= dig_q;
        res_ovf   <= ovf_q;
        rr_ptr    <= rr_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_CONV && core_done) begin
      dig_q <= {d3, d2, d1, d0};
      ovf_q <= 1'b0;
    end else if (state_q == S_SAT) begin
      dig_q <= 16'h9999;
      ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: directed corners plus randomized single and burst requests.
module tb_bcd_conv_sched;

  localparam int NREQ = 4;
  localparam int W    = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] bin_in;
  logic [NREQ-1:0]   ack;
  logic              res_valid;
  logic [1:0]        res_id;
  logic [15:0]       res_bcd;
  logic              res_ovf;
  logic              busy;

  int errs = 0, checks = 0;
  int ack_cnt = 0, exp_acks = 0, mptr = 0;
  int bv[NREQ];

  always #5 clk = ~clk;

  bcd_conv_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bin_in    (bin_in),
    .ack       (ack),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_bcd   (res_bcd),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  always @(negedge clk) ack_cnt += $countones(ack);

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int ref_lat(input int v);
    if (v > 9999) return 2;
    return 1 + (v / 1000 + 1) + ((v / 100) % 10 + 1) + ((v / 10) % 10 + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single request on one requester; optionally disturb bin_in one cycle after the grant.
  task automatic run_one(input int id, input int v, input bit chg);
    int  n;
    bit  seen;
    @(negedge clk);
    bin_in[id*W +: W] = W'(v);
    req[id] = 1'b1;
    @(posedge clk); #1;
    chk("busy_at_grant", busy, 1);
    n = 0; seen = 0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(posedge clk); #1;
      if (chg && c == 1) bin_in[id*W +: W] = W'(7777);
      if (res_valid) begin seen = 1; n = c; end
    end
    chk("res_seen", seen, 1);
    chk("latency", n, ref_lat(v));
    chk("res_bcd", res_bcd, ref_bcd(v));
    chk("res_id", res_id, id);
    chk("res_ovf", res_ovf, (v > 9999) ? 1 : 0);
    chk("ack", ack, 1 << id);
    chk("busy_at_valid", busy, 0);
    if (seen) exp_acks++;
    mptr = (id + 1) % NREQ;
    @(negedge clk);
    req[id] = 1'b0;
  endtask

  // Several requesters at once; order predicted from the round-robin pointer in the model.
  task automatic burst(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pend;
    int  eid, gid;
    bit  seen;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) if (mask[i]) bin_in[i*W +: W] = W'(bv[i]);
    req  = req | mask;
    pend = mask;
    while (pend != '0) begin
      eid = -1;
      for (int k = 0; k < NREQ; k++)
        if (eid < 0 && pend[(mptr + k) % NREQ]) eid = (mptr + k) % NREQ;
      seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(posedge clk); #1;
        if (res_valid) seen = 1;
      end
      chk("burst_seen", seen, 1);
      if (!seen) break;
      gid = int'(res_id);
      exp_acks++;
      chk("burst_id", res_id, eid);
      chk("burst_bcd", res_bcd, ref_bcd(bv[eid]));
      chk("burst_ovf", res_ovf, (bv[eid] > 9999) ? 1 : 0);
      chk("burst_ack", ack, 1 << eid);
      pend[gid] = 1'b0;
      mptr = (gid + 1) % NREQ;
      @(negedge clk);
      req[gid] = 1'b0;
    end
  endtask

  initial begin
    int v, id, cnt;
    logic [NREQ-1:0] m;
    int corners[6] = '{0, 9, 10, 999, 1000, 9999};

    // All four requesters pending from reset
    rst = 1'b1;
    req = 4'b1111;
    bv[0] = 5; bv[1] = 50; bv[2] = 500; bv[3] = 5000;
    for (int i = 0; i < NREQ; i++) bin_in[i*W +: W] = W'(bv[i]);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_ack", ack, 0);
    chk("rst_id", res_id, 0);
    chk("rst_bcd", res_bcd, 0);
    chk("rst_ovf", res_ovf, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    burst(4'b1111);
    repeat (3) @(negedge clk);

    run_one(0, 1234, 0);
    for (int i = 0; i < 6; i++) run_one(i % NREQ, corners[i], 0);
    run_one(2, 12000, 0);

    // Asynchronous reset in the middle of a conversion
    @(negedge clk);
    bin_in[1*W +: W] = W'(8888);
    req[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("busy_conv", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_id", res_id, 0);
    chk("mid_rst_bcd", res_bcd, 0);
    chk("mid_rst_ovf", res_ovf, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    req[1] = 1'b0;
    rst = 1'b0;
    mptr = 0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    chk("no_result_after_rst", cnt, 0);
    run_one(3, 8888, 0);

    run_one(1, 4321, 1);

    // Randomized single requests, including saturating values
    for (int t = 0; t < 20; t++) begin
      id = $urandom_range(0, NREQ - 1);
      v  = ($urandom_range(0, 4) == 0) ? $urandom_range(10000, 16383) : $urandom_range(0, 9999);
      run_one(id, v, 0);
    end

    // Randomized bursts
    for (int t = 0; t < 6; t++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++)
        bv[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(10000, 16383) : $urandom_range(0, 9999);
      burst(m);
      repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("ack_total", ack_cnt, exp_acks);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
